// File: rtl/rv_iommu_ds_wr_arb.sv
// Write-path scheduler for the IOMMU data-structure AXI port.
// Arbitrates CQ/FQ/MSI-IG/MRIF writers onto one AW/W master, serialises
// bursts, rewrites AWID to the requester index and routes B back by ID.

package rv_iommu_ds_wr_arb_pkg;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } aw_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

endpackage

module rv_iommu_ds_wr_arb #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned IdWidth        = rv_iommu_ds_wr_arb_pkg::IdWidth,
  parameter int unsigned MaxOutstanding = 4,
  parameter type aw_chan_t = rv_iommu_ds_wr_arb_pkg::aw_chan_t,
  parameter type w_chan_t  = rv_iommu_ds_wr_arb_pkg::w_chan_t,
  parameter type b_chan_t  = rv_iommu_ds_wr_arb_pkg::b_chan_t
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  aw_chan_t [NumReq-1:0] req_aw_i,
  input  logic     [NumReq-1:0] req_aw_valid_i,
  output logic     [NumReq-1:0] req_aw_ready_o,
  input  w_chan_t  [NumReq-1:0] req_w_i,
  input  logic     [NumReq-1:0] req_w_valid_i,
  output logic     [NumReq-1:0] req_w_ready_o,
  output b_chan_t               req_b_o,
  output logic     [NumReq-1:0] req_b_valid_o,
  input  logic     [NumReq-1:0] req_b_ready_i,
  output aw_chan_t              mst_aw_o,
  output logic                  mst_aw_valid_o,
  input  logic                  mst_aw_ready_i,
  output w_chan_t               mst_w_o,
  output logic                  mst_w_valid_o,
  input  logic                  mst_w_ready_i,
  input  b_chan_t               mst_b_i,
  input  logic                  mst_b_valid_i,
  output logic                  mst_b_ready_o,
  output logic                  busy_o,
  output logic                  unexp_b_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q;
  logic [IdxW-1:0] gnt_q;
  logic [IdxW-1:0] gnt_idx;
  logic            gnt_found;
  int unsigned     cand;
  aw_chan_t        aw_q;
  aw_chan_t        aw_sel;
  logic [CntW-1:0] cnt_q [NumReq];
  logic [NumReq-1:0] elig;
  logic [NumReq-1:0] cnt_inc;
  logic [NumReq-1:0] cnt_dec;
  logic            aw_grant;
  logic            w_last_hs;
  logic            b_id_ok;
  logic            b_hit;
  logic [IdxW-1:0] b_idx;
  logic            unexp_b_q;

  // A requester competes only while it has AW valid and headroom in its counter
  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      elig[i] = req_aw_valid_i[i] && (cnt_q[i] < CntW'(MaxOutstanding));
    end
  end

  // Round-robin search for the first eligible index starting at rr_ptr
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = (32'(rr_ptr_q) + k) % NumReq;
      if (!gnt_found && elig[IdxW'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IdxW'(cand);
      end
    end
  end

  // No handshake may be offered while reset is held: nothing would latch it
  assign aw_grant  = (state_q == ST_IDLE) && gnt_found && rst_ni;
  assign w_last_hs = (state_q == ST_W) && req_w_valid_i[gnt_q] && mst_w_ready_i
                     && req_w_i[gnt_q].last;

  // Granted AW payload with its ID replaced by the requester index
  always_comb begin
    aw_sel    = req_aw_i[gnt_idx];
    aw_sel.id = IdWidth'(gnt_idx);
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: grant, forward AW, stream W until last beat
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (aw_grant)       state_d = ST_AW;
      ST_AW:   if (mst_aw_ready_i) state_d = ST_W;
      ST_W:    if (w_last_hs)      state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state; W is a pass-through of the owner
  always_comb begin
    req_aw_ready_o = '0;
    req_w_ready_o  = '0;
    mst_aw_valid_o = 1'b0;
    mst_w_valid_o  = 1'b0;
    case (state_q)
      ST_IDLE: if (aw_grant) req_aw_ready_o[gnt_idx] = 1'b1;
      ST_AW:   mst_aw_valid_o = 1'b1;
      ST_W: begin
        mst_w_valid_o        = req_w_valid_i[gnt_q];
        req_w_ready_o[gnt_q] = mst_w_ready_i;
      end
      default: ;
    endcase
  end

  assign mst_aw_o = aw_q;
  assign mst_w_o  = req_w_i[gnt_q];
  assign req_b_o  = mst_b_i;

  // Capture the granted burst and advance the round-robin pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_q     <= '0;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else if (aw_grant) begin
      aw_q     <= aw_sel;
      gnt_q    <= gnt_idx;
      rr_ptr_q <= (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + IdxW'(1);
    end
  end

  // B routing by ID; unknown IDs or idle requesters are swallowed
  always_comb begin
    req_b_valid_o = '0;
    mst_b_ready_o = 1'b1;
    cnt_dec       = '0;
    b_id_ok       = (32'(mst_b_i.id) < NumReq);
    b_idx         = IdxW'(mst_b_i.id);
    b_hit         = b_id_ok && (cnt_q[b_idx] != '0);
    if (b_hit) begin
      req_b_valid_o[b_idx] = mst_b_valid_i;
      mst_b_ready_o        = req_b_ready_i[b_idx];
      cnt_dec[b_idx]       = mst_b_valid_i && req_b_ready_i[b_idx];
    end
  end

  // Outstanding-write increment on AW handshake
  always_comb begin
    cnt_inc = '0;
    if ((state_q == ST_AW) && mst_aw_ready_i) cnt_inc[gnt_q] = 1'b1;
  end

  // Per-requester outstanding counters; simultaneous inc and dec cancel
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumReq; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (cnt_inc[i] && !cnt_dec[i])      cnt_q[i] <= cnt_q[i] + CntW'(1);
        else if (!cnt_inc[i] && cnt_dec[i]) cnt_q[i] <= cnt_q[i] - CntW'(1);
      end
    end
  end

  // Registered one-cycle flag for every dropped B beat
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) unexp_b_q <= 1'b0;
    else         unexp_b_q <= mst_b_valid_i && !b_hit;
  end

  assign unexp_b_o = unexp_b_q;

  // Busy while a burst is in flight or any write awaits its response
  always_comb begin
    busy_o = (state_q != ST_IDLE);
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (cnt_q[i] != '0) busy_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_rv_iommu_ds_wr_arb.sv
// Self-checking bench for rv_iommu_ds_wr_arb: directed scenarios followed by
// randomized traffic, checked against a transaction-level arbiter model.

module tb_rv_iommu_ds_wr_arb;
  import rv_iommu_ds_wr_arb_pkg::*;

  localparam int NR   = 4;
  localparam int MAXO = 4;
  localparam int MAXC = 200;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  aw_chan_t [NR-1:0]  req_aw_i;
  logic     [NR-1:0]  req_aw_valid_i;
  logic     [NR-1:0]  req_aw_ready_o;
  w_chan_t  [NR-1:0]  req_w_i;
  logic     [NR-1:0]  req_w_valid_i;
  logic     [NR-1:0]  req_w_ready_o;
  b_chan_t            req_b_o;
  logic     [NR-1:0]  req_b_valid_o;
  logic     [NR-1:0]  req_b_ready_i;
  aw_chan_t           mst_aw_o;
  logic               mst_aw_valid_o;
  logic               mst_aw_ready_i;
  w_chan_t            mst_w_o;
  logic               mst_w_valid_o;
  logic               mst_w_ready_i;
  b_chan_t            mst_b_i;
  logic               mst_b_valid_i;
  logic               mst_b_ready_o;
  logic               busy_o;
  logic               unexp_b_o;

  rv_iommu_ds_wr_arb #(
    .NumReq(NR), .IdWidth(4), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_aw_i(req_aw_i), .req_aw_valid_i(req_aw_valid_i), .req_aw_ready_o(req_aw_ready_o),
    .req_w_i(req_w_i), .req_w_valid_i(req_w_valid_i), .req_w_ready_o(req_w_ready_o),
    .req_b_o(req_b_o), .req_b_valid_o(req_b_valid_o), .req_b_ready_i(req_b_ready_i),
    .mst_aw_o(mst_aw_o), .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i),
    .mst_w_o(mst_w_o), .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(mst_w_ready_i),
    .mst_b_i(mst_b_i), .mst_b_valid_i(mst_b_valid_i), .mst_b_ready_o(mst_b_ready_o),
    .busy_o(busy_o), .unexp_b_o(unexp_b_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: round-robin start index and outstanding writes
  int rr = 0;
  int exp_cnt [NR];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] v;
    v = '0;
    v[2'(i)] = 1'b1;
    return v;
  endfunction

  function automatic logic [NR-1:0] elig(input logic [NR-1:0] mask);
    logic [NR-1:0] e;
    for (int i = 0; i < NR; i++) e[i] = mask[i] && (exp_cnt[i] < MAXO);
    return e;
  endfunction

  function automatic int pick(input logic [NR-1:0] e, input int start);
    for (int k = 0; k < NR; k++) begin
      if (e[2'((start + k) % NR)]) return (start + k) % NR;
    end
    return -1;
  endfunction

  task automatic aw_phase(input logic [NR-1:0] mask, input int beats, input bit bsame,
                          output int g);
    aw_chan_t exp_aw;
    int waits;
    bit do_b;
    for (int i = 0; i < NR; i++) begin
      req_aw_i[i].id    = 4'($urandom);
      req_aw_i[i].addr  = {$urandom, $urandom};
      req_aw_i[i].len   = 8'(beats - 1);
      req_aw_i[i].size  = 3'd3;
      req_aw_i[i].burst = 2'd1;
    end
    req_aw_valid_i = mask;
    g = pick(elig(mask), rr);
    if (g < 0) g = 0;
    exp_aw    = req_aw_i[g];
    exp_aw.id = 4'(g);
    @(negedge clk_i);
    chk("aw_grant", 128'(req_aw_ready_o), 128'(onehot(g)));
    chk("aw_valid_early", 128'(mst_aw_valid_o), 128'(1'b0));
    step();
    req_aw_valid_i = '0;
    rr = (g + 1) % NR;
    req_aw_i[g].addr = ~req_aw_i[g].addr;
    waits = $urandom_range(0, 2);
    for (int w = 0; w < waits; w++) begin
      @(negedge clk_i);
      chk("aw_hold_valid", 128'(mst_aw_valid_o), 128'(1'b1));
      chk("aw_hold_payload", 128'(mst_aw_o), 128'(exp_aw));
      step();
    end
    do_b = bsame && (exp_cnt[g] > 0);
    mst_aw_ready_i = 1'b1;
    if (do_b) begin
      mst_b_i.id    = 4'(g);
      mst_b_i.resp  = 2'($urandom);
      mst_b_valid_i = 1'b1;
      req_b_ready_i = '1;
    end
    @(negedge clk_i);
    chk("aw_valid", 128'(mst_aw_valid_o), 128'(1'b1));
    chk("aw_payload", 128'(mst_aw_o), 128'(exp_aw));
    chk("aw_ready_busy", 128'(req_aw_ready_o), 128'(0));
    if (do_b) chk("b_same_cycle", 128'(req_b_valid_o), 128'(onehot(g)));
    step();
    exp_cnt[g]++;
    if (do_b) exp_cnt[g]--;
    mst_aw_ready_i = 1'b0;
    mst_b_valid_i  = 1'b0;
    req_b_ready_i  = '0;
  endtask

  task automatic w_phase(input int g, input int beats, input int mode);
    int sent = 0;
    int cyc  = 0;
    bit rdy;
    bit need = 1'b1;
    w_chan_t cur;
    while (sent < beats && cyc < MAXC) begin
      if (need) begin
        cur.data = {$urandom, $urandom};
        cur.strb = 8'($urandom);
        cur.last = (sent == beats - 1);
        need = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
        req_w_i[i].data = {$urandom, $urandom};
        req_w_i[i].strb = 8'($urandom);
        req_w_i[i].last = 1'($urandom);
      end
      req_w_i[g]    = cur;
      req_w_valid_i = '1;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom);
      endcase
      mst_w_ready_i = rdy;
      @(negedge clk_i);
      chk("w_valid", 128'(mst_w_valid_o), 128'(1'b1));
      chk("w_data", 128'(mst_w_o), 128'(cur));
      chk("w_ready_route", 128'(req_w_ready_o), 128'(rdy ? onehot(g) : 4'h0));
      chk("aw_ready_in_w", 128'(req_aw_ready_o), 128'(0));
      step();
      if (rdy) begin
        sent++;
        need = 1'b1;
      end
      cyc++;
    end
    if (sent < beats) chk("w_timeout", 128'(sent), 128'(beats));
    req_w_valid_i = '1;
    mst_w_ready_i = 1'b1;
    @(negedge clk_i);
    chk("w_valid_idle", 128'(mst_w_valid_o), 128'(1'b0));
    chk("w_ready_idle", 128'(req_w_ready_o), 128'(0));
    chk("aw_valid_idle", 128'(mst_aw_valid_o), 128'(1'b0));
    step();
    req_w_valid_i = '0;
    mst_w_ready_i = 1'b0;
  endtask

  task automatic send_b(input int id, input logic [NR-1:0] rdy);
    bit hit;
    bit hs = 1'b0;
    int tries = 0;
    logic [NR-1:0] r;
    r = rdy;
    hit = (id < NR) ? (exp_cnt[id] > 0) : 1'b0;
    mst_b_i.id    = 4'(id);
    mst_b_i.resp  = 2'($urandom);
    mst_b_valid_i = 1'b1;
    while (!hs && tries < 4) begin
      req_b_ready_i = r;
      @(negedge clk_i);
      chk("b_valid_route", 128'(req_b_valid_o), 128'(hit ? onehot(id) : 4'h0));
      chk("b_ready", 128'(mst_b_ready_o), 128'(hit ? r[2'(id)] : 1'b1));
      chk("b_payload", 128'(req_b_o), 128'(mst_b_i));
      hs = hit ? r[2'(id)] : 1'b1;
      step();
      r = '1;
      tries++;
    end
    if (hit) exp_cnt[id]--;
    mst_b_valid_i = 1'b0;
    req_b_ready_i = '0;
    @(negedge clk_i);
    chk("unexp_pulse", 128'(unexp_b_o), 128'(!hit));
    step();
    @(negedge clk_i);
    chk("unexp_clear", 128'(unexp_b_o), 128'(1'b0));
    step();
  endtask

  task automatic chk_idle();
    bit any = 1'b0;
    for (int i = 0; i < NR; i++) if (exp_cnt[i] > 0) any = 1'b1;
    @(negedge clk_i);
    chk("busy", 128'(busy_o), 128'(any));
    chk("aw_valid_quiet", 128'(mst_aw_valid_o), 128'(1'b0));
    step();
  endtask

  task automatic check_blocked(input logic [NR-1:0] mask, input int n);
    req_aw_valid_i = mask;
    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      chk("aw_masked", 128'(req_aw_ready_o), 128'(0));
      step();
    end
    req_aw_valid_i = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < NR; i++) begin
      while (exp_cnt[i] > 0) send_b(i, '1);
    end
  endtask

  initial begin
    int g;
    logic [NR-1:0] mask;
    for (int i = 0; i < NR; i++) exp_cnt[i] = 0;
    rst_ni         = 1'b0;
    req_aw_i       = '0;
    req_aw_valid_i = '1;
    req_w_i        = '0;
    req_w_valid_i  = '1;
    req_b_ready_i  = '1;
    mst_aw_ready_i = 1'b1;
    mst_w_ready_i  = 1'b1;
    mst_b_i        = '0;
    mst_b_valid_i  = 1'b1;

    // Reset: everything quiet, B sink open, nothing flagged
    #12;
    chk("rst_aw_ready", 128'(req_aw_ready_o), 128'(0));
    chk("rst_aw_valid", 128'(mst_aw_valid_o), 128'(1'b0));
    chk("rst_w_valid", 128'(mst_w_valid_o), 128'(1'b0));
    chk("rst_w_ready", 128'(req_w_ready_o), 128'(0));
    chk("rst_b_valid", 128'(req_b_valid_o), 128'(0));
    chk("rst_b_ready", 128'(mst_b_ready_o), 128'(1'b1));
    chk("rst_busy", 128'(busy_o), 128'(1'b0));
    chk("rst_unexp", 128'(unexp_b_o), 128'(1'b0));
    step();
    req_aw_valid_i = '0;
    req_w_valid_i  = '0;
    req_b_ready_i  = '0;
    mst_aw_ready_i = 1'b0;
    mst_w_ready_i  = 1'b0;
    mst_b_valid_i  = 1'b0;
    rst_ni         = 1'b1;
    chk_idle();

    // All requesters valid, single-beat bursts: rotation from index 0
    for (int n = 0; n < 5; n++) begin
      aw_phase('1, 1, 1'b0, g);
      w_phase(g, 1, 0);
    end
    drain();
    chk_idle();

    // Single 4-beat write from requester 2 and its response
    aw_phase(4'b0100, 4, 1'b0, g);
    w_phase(g, 4, 0);
    chk_idle();
    send_b(2, '1);
    chk_idle();

    // Outstanding limit masks requester 1 while requester 3 proceeds
    for (int n = 0; n < MAXO; n++) begin
      aw_phase(4'b0010, 1, 1'b0, g);
      w_phase(g, 1, 0);
    end
    check_blocked(4'b0010, 3);
    for (int n = 0; n < 2; n++) begin
      aw_phase(4'b1010, 1, 1'b0, g);
      w_phase(g, 1, 0);
    end
    send_b(1, '1);
    aw_phase(4'b1010, 1, 1'b0, g);
    w_phase(g, 1, 0);
    drain();
    chk_idle();

    // 8-beat burst under 1010 W backpressure with other requesters pushing W
    aw_phase(4'b0100, 8, 1'b0, g);
    w_phase(g, 8, 1);
    chk_idle();

    // Unknown IDs and responses for idle requesters are dropped
    send_b(7, '1);
    send_b(4, '1);
    send_b(0, '1);
    send_b(2, '0);

    // Same-cycle AW and B on requester 0 leave its count unchanged
    for (int n = 0; n < 2; n++) begin
      aw_phase(4'b0001, 1, 1'b0, g);
      w_phase(g, 1, 0);
    end
    aw_phase(4'b0001, 1, 1'b1, g);
    w_phase(g, 1, 0);
    send_b(0, '1);
    send_b(0, '1);
    chk_idle();
    send_b(0, '1);
    chk_idle();

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < NR; i++) begin
          if (exp_cnt[i] > 0 && $urandom_range(0, 1) == 1) begin
            send_b(i, 4'($urandom));
            break;
          end
        end
      end
      if ($urandom_range(0, 7) == 0) send_b($urandom_range(0, 15), 4'($urandom));
      mask = 4'($urandom);
      if (mask == '0) mask = onehot($urandom_range(0, NR - 1));
      if (elig(mask) == '0) begin
        for (int i = 0; i < NR; i++) begin
          if (mask[i]) begin
            send_b(i, '1);
            break;
          end
        end
      end
      aw_phase(mask, $urandom_range(1, 4), 1'($urandom), g);
      w_phase(g, (exp_cnt[g] >= 0) ? int'(mst_aw_o.len) + 1 : 1, $urandom_range(0, 2));
    end
    drain();
    chk_idle();

    // Reset in the middle of a burst
    aw_phase(4'b0100, 4, 1'b0, g);
    req_w_i[g].data = {$urandom, $urandom};
    req_w_i[g].strb = '1;
    req_w_i[g].last = 1'b0;
    req_w_valid_i   = onehot(g);
    mst_w_ready_i   = 1'b1;
    @(negedge clk_i);
    chk("w_before_rst", 128'(mst_w_valid_o), 128'(1'b1));
    step();
    #2;
    rst_ni         = 1'b0;
    req_aw_valid_i = '1;
    #1;
    chk("midrst_w_valid", 128'(mst_w_valid_o), 128'(1'b0));
    chk("midrst_w_ready", 128'(req_w_ready_o), 128'(0));
    chk("midrst_aw_valid", 128'(mst_aw_valid_o), 128'(1'b0));
    chk("midrst_aw_ready", 128'(req_aw_ready_o), 128'(0));
    chk("midrst_busy", 128'(busy_o), 128'(1'b0));
    chk("midrst_b_ready", 128'(mst_b_ready_o), 128'(1'b1));
    for (int i = 0; i < NR; i++) exp_cnt[i] = 0;
    rr = 0;
    step();
    req_aw_valid_i = '0;
    req_w_valid_i  = '0;
    mst_w_ready_i  = 1'b0;
    rst_ni         = 1'b1;
    send_b(2, '1);
    chk_idle();
    aw_phase('1, 1, 1'b0, g);
    w_phase(g, 1, 0);
    drain();
    chk_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv_iommu_ds_wr_arb.md
Name: rv_iommu_ds_wr_arb

Overview:
- Write-path scheduler for the IOMMU data-structure AXI port: arbitrates the memory-writing requesters (CQ, FQ, MSI IG, MRIF handler) onto one AW/W master channel.
- Serialises bursts (AW then all W beats of the same requester) and rewrites AWID to the requester index.
- Tracks outstanding writes per requester and routes B responses back by ID.

Parameters:
- NumReq, 4, number of write requesters; index 0 has highest priority at reset.
- IdWidth, 4, AXI ID width; NumReq <= 2**IdWidth.
- MaxOutstanding, 4, max un-responded AWs per requester (>= 1).
- aw_chan_t / w_chan_t / b_chan_t, logic, AXI channel struct types.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_aw_i  in  NumReq x aw_chan_t  requester AW payloads
- req_aw_valid_i  in  NumReq  AW valid per requester
- req_aw_ready_o  out  NumReq  AW ready per requester
- req_w_i  in  NumReq x w_chan_t  requester W payloads
- req_w_valid_i  in  NumReq  W valid
- req_w_ready_o  out  NumReq  W ready
- req_b_o  out  b_chan_t  B payload, broadcast to all requesters
- req_b_valid_o  out  NumReq  B valid per requester
- req_b_ready_i  in  NumReq  B ready per requester
- mst_aw_o / mst_aw_valid_o / mst_aw_ready_i  out/out/in  aw_chan_t/1/1  master AW
- mst_w_o / mst_w_valid_o / mst_w_ready_i  out/out/in  w_chan_t/1/1  master W
- mst_b_i / mst_b_valid_i / mst_b_ready_o  in/in/out  b_chan_t/1/1  master B
- busy_o  out  1  state != IDLE or any outstanding counter != 0
- unexp_b_o  out  1  one-cycle pulse on a dropped B

Behaviour:
- FSM states: IDLE, AW, W. All registers reset asynchronously:
  - state=IDLE, rr_ptr=0, counters=0, aw_q=0.
  - Outputs in reset: all valid and ready outputs 0 except mst_b_ready_o (see B routing); busy_o=0; unexp_b_o=0.
- Eligibility: requester i is eligible when req_aw_valid_i[i]=1 and cnt[i] < MaxOutstanding.
- IDLE:
  - Round-robin pick of the first eligible index starting at rr_ptr.
  - req_aw_ready_o[gnt]=1 in the same cycle; latch payload into aw_q with id forced to gnt (zero-extended); latch gnt_q.
  - Move to AW; rr_ptr <= gnt+1 mod NumReq.
  - No eligible requester: stay in IDLE.
- AW:
  - mst_aw_valid_o=1, mst_aw_o=aw_q. Latency: requester handshake to mst_aw_valid_o = 1 cycle.
  - On mst_aw_ready_i: cnt[gnt_q]++ and move to W.
  - Payload and valid stay stable until the handshake.
- W:
  - mst_w_o=req_w_i[gnt_q], mst_w_valid_o=req_w_valid_i[gnt_q], req_w_ready_o[gnt_q]=mst_w_ready_i; all other W readies 0.
  - On a handshake with w.last=1, move to IDLE. No new grant in that same cycle, so there is at least one idle cycle between bursts.
- Outside W, all req_w_ready_o=0 and mst_w_valid_o=0. W beats presented early by requesters are held off.
- B routing (combinational): idx = mst_b_i.id.
  - If idx < NumReq and cnt[idx] > 0: req_b_valid_o[idx]=mst_b_valid_i and mst_b_ready_o=req_b_ready_i[idx]. On handshake, cnt[idx]--.
  - Otherwise (bad ID or zero count): mst_b_ready_o=1, B is dropped, unexp_b_o pulses on mst_b_valid_i. With counters at 0 (including during reset) mst_b_ready_o=1.
- Same-cycle increment (AW handshake) and decrement (B handshake) on one counter: net unchanged.
- Counter width is clog2(MaxOutstanding+1). A counter at max masks its requester; it never saturates past max.
- Reset asserted mid-burst returns to IDLE immediately with counters cleared. Outstanding Bs arriving later are dropped through the unexpected path.

Test Plan:
- Single write, requester 2, awlen=3: mst_aw_valid_o rises 1 cycle after req_aw_valid_i; AWID=2; 4 W beats pass only from requester 2; IDLE after last; B id=2 raises req_b_valid_o[2] only; cnt[2] back to 0; busy_o drops.
- All 4 requesters valid continuously, single-beat bursts: grant order 0,1,2,3,0; each AWID equals its index.
- MaxOutstanding=4 with B withheld: requester 1 issues 4 AWs, 5th req_aw_valid_i[1] is never acknowledged while requester 3 keeps being granted; one B id=1 re-enables requester 1.
- W backpressure: mst_w_ready_i toggling 1010 over an 8-beat burst yields exactly 8 beats in order. Requester 0 presenting W during the burst sees req_w_ready_o[0]=0.
- B with id=7 (NumReq=4), or id=0 with cnt[0]=0: mst_b_ready_o=1, no req_b_valid_o, unexp_b_o high for 1 cycle.
- Same-cycle AW handshake and B handshake for requester 0 with cnt[0]=2: cnt[0] stays 2. rst_ni low during W state: state IDLE, all valids 0 asynchronously.
